data_mem_bridge: RTL and testbench

Data-side memory and I/O bridge directly downstream of the CPU core's data port. It consumes the core's `mem_rd`, `mem_wr`, `ram_addr` and `data_mem_in`, and returns `data_mem_out`. It decodes the 12-bit address space into a word RAM and a small memory-mapped peripheral page. The peripheral page holds an output FIFO with a valid/ready stream, a GPIO input port, and a reloadable down-counting timer with an interrupt pulse.

---
 rtl/data_mem_bridge_if.sv | 22 ++
 rtl/data_mem_bridge.sv | 151 +++++++++++++++
 tb/tb_data_mem_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_bridge_if.sv
// Core data-port bus plus the output FIFO stream, bundled for the bridge.
// Stream handshake: a word transfers on every rising edge where out_valid && out_ready.
interface data_mem_bridge_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [11:0] ram_addr;
    logic [15:0] data_mem_in;
    logic [15:0] data_mem_out;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output mem_rd, mem_wr, ram_addr, data_mem_in, out_ready,
        input  data_mem_out, out_data, out_valid
    );

    modport slave (
        input  mem_rd, mem_wr, ram_addr, data_mem_in, out_ready,
        output data_mem_out, out_data, out_valid
    );
endinterface

// File: rtl/data_mem_bridge.sv
// Data-side bridge: word RAM below 0xF00, peripheral page (status, output FIFO,
// GPIO, reloadable down-counting timer) at 0xF00-0xF04.
module data_mem_bridge #(
    parameter int RAM_WORDS  = 3840,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_bridge_if.slave   bus,
    input  logic [15:0]        gpio_in,
    output logic               timer_irq
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [11:0] ADDR_STATUS = 12'hF00;
    localparam logic [11:0] ADDR_OUT    = 12'hF01;
    localparam logic [11:0] ADDR_GPIO   = 12'hF02;
    localparam logic [11:0] ADDR_TIMER  = 12'hF03;
    localparam logic [11:0] ADDR_CTRL   = 12'hF04;

    logic [15:0]      ram [RAM_WORDS];
    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [15:0]      count;
    logic [15:0]      reload;
    logic             enable;
    logic             timer_exp;
    logic             fifo_ovf;

    logic       ram_sel;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic       push_ok;
    logic       ovf_set;
    logic       timer_wr;
    logic       ctrl_wr;
    logic       sticky_clr;
    logic       timer_fire;
    logic [2:0] count_field;
    logic [15:0] rd_data;

    assign ram_sel    = bus.ram_addr < 12'(RAM_WORDS);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));

    assign push    = bus.mem_wr && (bus.ram_addr == ADDR_OUT);
    assign pop     = !fifo_empty && bus.out_ready;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push_ok = push && (!fifo_full || pop);
    assign ovf_set = push && fifo_full && !pop;

    assign timer_wr   = bus.mem_wr && (bus.ram_addr == ADDR_TIMER);
    assign ctrl_wr    = bus.mem_wr && (bus.ram_addr == ADDR_CTRL);
    assign sticky_clr = ctrl_wr && bus.data_mem_in[1];
    assign timer_fire = enable && (count == '0) && !timer_wr;

    assign count_field   = 3'(fifo_count);
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];

    always_comb begin
        rd_data = '0;
        if (bus.mem_rd) begin
            if (ram_sel) begin
                rd_data = ram[bus.ram_addr];
            end else begin
                case (bus.ram_addr)
                    ADDR_STATUS: rd_data = {9'b0, count_field, fifo_ovf, timer_exp,
                                            fifo_full, fifo_empty};
                    ADDR_GPIO:   rd_data = gpio_in;
                    ADDR_TIMER:  rd_data = count;
                    ADDR_CTRL:   rd_data = {15'b0, enable};
                    default:     rd_data = '0;
                endcase
            end
        end
    end
    assign bus.data_mem_out = rd_data;

    // Storage arrays carry no reset; only pointers and flags define their meaning.
    always_ff @(posedge clk) begin
        if (bus.mem_wr && ram_sel) begin
            ram[bus.ram_addr] <= bus.data_mem_in;
        end
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.data_mem_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky bits: a set event in the same cycle as a W1C clear leaves the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            reload    <= '0;
            enable    <= 1'b0;
            timer_exp <= 1'b0;
            fifo_ovf  <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= timer_fire;
            if (timer_wr) begin
                count  <= bus.data_mem_in;
                reload <= bus.data_mem_in;
            end else if (enable) begin
                if (count == '0) begin
                    count <= reload;
                end else begin
                    count <= count - 16'd1;
                end
            end
            if (ctrl_wr) begin
                enable <= bus.data_mem_in[0];
            end
            if (timer_fire) begin
                timer_exp <= 1'b1;
            end else if (sticky_clr) begin
                timer_exp <= 1'b0;
            end
            if (ovf_set) begin
                fifo_ovf <= 1'b1;
            end else if (sticky_clr) begin
                fifo_ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: directed scenarios plus a randomized run, all checked
// against a cycle-level behavioural model (queue FIFO, integer timer, sparse RAM).
module tb_data_mem_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] gpio_in;
  logic        timer_irq;

  data_mem_bridge_if bus ();

  data_mem_bridge #(.RAM_WORDS(3840), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .gpio_in   (gpio_in),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [15:0] m_q[$];
  logic [15:0] m_ram[int];
  int          m_count;
  int          m_reload;
  bit          m_en;
  bit          m_exp;
  bit          m_ovf;
  bit          m_irq;

  localparam int DEPTH = 4;

  task automatic drive(input bit rd, input bit wr, input logic [11:0] a, input logic [15:0] d);
    bus.mem_rd      = rd;
    bus.mem_wr      = wr;
    bus.ram_addr    = a;
    bus.data_mem_in = d;
  endtask

  // Advance the model by one rising edge using the inputs the bench is driving.
  task automatic model_edge();
    bit pop, push, ovf_set, tw, fire, cw, clr;
    int a;
    logic [15:0] d;
    a = int'(bus.ram_addr);
    d = bus.data_mem_in;
    if (reset) begin
      m_q.delete();
      m_count = 0; m_reload = 0; m_en = 0; m_exp = 0; m_ovf = 0; m_irq = 0;
      return;
    end
    pop     = (m_q.size() > 0) && bus.out_ready;
    push    = bus.mem_wr && (a == 'hF01);
    ovf_set = push && (m_q.size() == DEPTH) && !pop;
    tw      = bus.mem_wr && (a == 'hF03);
    cw      = bus.mem_wr && (a == 'hF04);
    clr     = cw && d[1];
    fire    = m_en && (m_count == 0) && !tw;
    if (bus.mem_wr && a < 'hF00) m_ram[a] = d;
    if (pop) void'(m_q.pop_front());
    if (push && !ovf_set) m_q.push_back(d);
    m_irq = fire;
    if (tw) begin
      m_count = int'(d); m_reload = int'(d);
    end else if (m_en) begin
      m_count = (m_count == 0) ? m_reload : m_count - 1;
    end
    if (cw) m_en = d[0];
    m_exp = fire ? 1'b1 : (clr ? 1'b0 : m_exp);
    m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
  endtask

  function automatic logic [15:0] exp_read(input bit rd, input int a);
    logic [15:0] v;
    int n;
    n = m_q.size();
    if (!rd) return 16'h0000;
    if (a < 'hF00) return m_ram.exists(a) ? m_ram[a] : 16'hxxxx;
    case (a)
      'hF00: begin
        v = 16'(n) << 4;
        v[0] = (n == 0); v[1] = (n == DEPTH); v[2] = m_exp; v[3] = m_ovf;
        return v;
      end
      'hF02: return gpio_in;
      'hF03: return 16'(m_count);
      'hF04: return {15'b0, m_en};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic write_op(input logic [11:0] a, input logic [15:0] d);
    drive(0, 1, a, d);
    step();
  endtask

  task automatic test_reset();
    logic [15:0] e;
    reset = 1'b1;
    bus.out_ready = 1'b0;
    gpio_in = 16'h0000;
    drive(0, 0, 12'h000, 16'h0000);
    step();
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    if (bus.out_valid !== 1'b0) errors++;
    checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h want=0000", bus.out_data); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", timer_irq); end
    drive(1, 0, 12'hF00, 0); #1;
    e = exp_read(1, 'hF00);
    checks++; if (bus.data_mem_out !== 16'h0001 || e !== 16'h0001) begin errors++; $display("FAIL reset_status got=%h want=0001", bus.data_mem_out); end
    step();
    drive(1, 0, 12'hF03, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0000) begin errors++; $display("FAIL reset_timer got=%h want=0000", bus.data_mem_out); end
    step();
    drive(1, 0, 12'hF04, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0000) begin errors++; $display("FAIL reset_ctrl got=%h want=0000", bus.data_mem_out); end
    step();
  endtask

  task automatic test_ram();
    drive(0, 1, 12'h123, 16'hBEEF); #1;
    checks++; if (bus.data_mem_out !== 16'h0000) begin errors++; $display("FAIL ram_gate_on_write got=%h want=0000", bus.data_mem_out); end
    step();
    drive(1, 0, 12'h123, 0); #1;
    checks++; if (bus.data_mem_out !== 16'hBEEF) begin errors++; $display("FAIL ram_read got=%h want=beef", bus.data_mem_out); end
    step();
    drive(0, 0, 12'h123, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0000) begin errors++; $display("FAIL ram_rd_gate got=%h want=0000", bus.data_mem_out); end
    step();
    drive(1, 1, 12'h123, 16'h1234); #1;
    checks++; if (bus.data_mem_out !== 16'hBEEF) begin errors++; $display("FAIL ram_rw_prewrite got=%h want=beef", bus.data_mem_out); end
    step();
    drive(1, 0, 12'h123, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h1234) begin errors++; $display("FAIL ram_rw_commit got=%h want=1234", bus.data_mem_out); end
    step();
    write_op(12'hEFF, 16'h7777);
    drive(1, 0, 12'hEFF, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h7777) begin errors++; $display("FAIL ram_top_word got=%h want=7777", bus.data_mem_out); end
    step();
  endtask

  task automatic test_fifo_overflow();
    bus.out_ready = 1'b0;
    drive(0, 1, 12'hF01, 16'h0001); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fifo_no_fallthrough got=%b want=0", bus.out_valid); end
    step();
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0001) begin
      errors++; $display("FAIL fifo_first_push valid=%b data=%h want 1/0001", bus.out_valid, bus.out_data);
    end
    for (int i = 2; i <= 5; i++) write_op(12'hF01, 16'(i));
    drive(1, 0, 12'hF00, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h004A || exp_read(1, 'hF00) !== 16'h004A) begin
      errors++; $display("FAIL fifo_status_full got=%h want=004a", bus.data_mem_out);
    end
    step();
    bus.out_ready = 1'b1;
    drive(0, 0, 12'h000, 0);
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== m_q[0] || bus.out_data !== 16'(i)) begin
        errors++; $display("FAIL fifo_drain_%0d valid=%b data=%h want 1/%h", i, bus.out_valid, bus.out_data, 16'(i));
      end
      step();
    end
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained_valid got=%b want=0", bus.out_valid); end
    drive(1, 0, 12'hF00, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0009) begin errors++; $display("FAIL fifo_status_after got=%h want=0009", bus.data_mem_out); end
    step();
    write_op(12'hF04, 16'h0002);
    drive(1, 0, 12'hF00, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0001) begin errors++; $display("FAIL fifo_ovf_clear got=%h want=0001", bus.data_mem_out); end
    step();
  endtask

  task automatic test_full_push_pop();
    bus.out_ready = 1'b1;
    drive(0, 1, 12'hF01, 16'h00C3); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL empty_pushpop_valid got=%b want=0", bus.out_valid); end
    step(); #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00C3) begin
      errors++; $display("FAIL empty_pushpop_next valid=%b data=%h want 1/00c3", bus.out_valid, bus.out_data);
    end
    drive(0, 0, 12'h000, 0);
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_op(12'hF01, 16'h0010 + 16'(i));
    bus.out_ready = 1'b1;
    write_op(12'hF01, 16'h00AA);
    bus.out_ready = 1'b0;
    drive(1, 0, 12'hF00, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0042 || exp_read(1, 'hF00) !== 16'h0042) begin
      errors++; $display("FAIL full_pushpop_status got=%h want=0042", bus.data_mem_out);
    end
    step();
    bus.out_ready = 1'b1;
    drive(0, 0, 12'h000, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.out_data !== m_q[0]) begin errors++; $display("FAIL full_pushpop_seq%0d got=%h want=%h", i, bus.out_data, m_q[0]); end
      step();
    end
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_pushpop_end valid=%b want=0", bus.out_valid); end
  endtask

  task automatic test_timer_period();
    int last = -1;
    int pulses = 0;
    bus.out_ready = 1'b0;
    write_op(12'hF03, 16'd3);
    write_op(12'hF04, 16'd1);
    drive(0, 0, 12'h000, 0);
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (timer_irq !== m_irq) begin errors++; $display("FAIL timer_irq_c%0d got=%b want=%b", i, timer_irq, m_irq); end
      if (timer_irq === 1'b1) begin
        if (last >= 0) begin
          checks++; if (i - last != 4) begin errors++; $display("FAIL timer_period got=%0d want=4", i - last); end
        end
        last = i;
        pulses++;
      end
      step();
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL timer_pulses got=%0d want=3", pulses); end
    drive(1, 0, 12'hF00, 0); #1;
    checks++; if (bus.data_mem_out[2] !== 1'b1) begin errors++; $display("FAIL timer_sticky got=%b want=1", bus.data_mem_out[2]); end
    step();
    write_op(12'hF04, 16'h0002);
    drive(1, 0, 12'hF00, 0); #1;
    checks++; if (bus.data_mem_out !== exp_read(1, 'hF00)) begin
      errors++; $display("FAIL timer_w1c got=%h want=%h", bus.data_mem_out, exp_read(1, 'hF00));
    end
    step();
    // reload 0: fires every enabled cycle
    write_op(12'hF03, 16'd0);
    write_op(12'hF04, 16'd1);
    drive(0, 0, 12'h000, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_reload0_c%0d got=%b want=1", i, timer_irq); end
      step();
    end
    drive(0, 1, 12'hF03, 16'd9);
    step(); #1;
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_write_priority got=%b want=0", timer_irq); end
    write_op(12'hF04, 16'h0002);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_op(12'hF01, 16'h0100 + 16'(i));
    write_op(12'hF03, 16'd5);
    write_op(12'hF04, 16'd1);
    drive(0, 0, 12'h000, 0);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b want=0", bus.out_valid); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got=%b want=0", timer_irq); end
    drive(1, 0, 12'hF03, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0000) begin errors++; $display("FAIL midreset_timer got=%h want=0000", bus.data_mem_out); end
    step();
    drive(1, 0, 12'hF00, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0001) begin errors++; $display("FAIL midreset_status got=%h want=0001", bus.data_mem_out); end
    step();
  endtask

  task automatic test_gpio_unmapped();
    gpio_in = 16'h5A5A;
    drive(1, 0, 12'hF7F, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0000) begin errors++; $display("FAIL unmapped_f7f got=%h want=0000", bus.data_mem_out); end
    step();
    drive(1, 0, 12'hF02, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h5A5A) begin errors++; $display("FAIL gpio_read got=%h want=5a5a", bus.data_mem_out); end
    step();
    write_op(12'hF02, 16'h1111);
    drive(1, 0, 12'hF02, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h5A5A) begin errors++; $display("FAIL gpio_write_ignored got=%h want=5a5a", bus.data_mem_out); end
    step();
    write_op(12'hF05, 16'hFFFF);
    drive(1, 0, 12'hF05, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0000) begin errors++; $display("FAIL unmapped_f05 got=%h want=0000", bus.data_mem_out); end
    step();
    drive(1, 0, 12'hF01, 0); #1;
    checks++; if (bus.data_mem_out !== 16'h0000) begin errors++; $display("FAIL out_data_read got=%h want=0000", bus.data_mem_out); end
    step();
  endtask

  task automatic test_random();
    int sel, a;
    logic [15:0] d, e;
    bit rd, wr;
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 9);
      a = (sel < 4) ? ('h100 + $urandom_range(0, 15)) : ('hF00 + sel - 4);
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) != 0);
      if (a == 'hF03) d = 16'($urandom_range(0, 6));
      else if (a == 'hF04) d = 16'($urandom_range(0, 3));
      else d = 16'($urandom);
      gpio_in = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      drive(rd, wr, 12'(a), d);
      #1;
      e = exp_read(rd, a);
      if (!$isunknown(e)) begin
        checks++; if (bus.data_mem_out !== e) begin errors++; $display("FAIL rnd_read_%0d addr=%h got=%h want=%h", n, a, bus.data_mem_out, e); end
      end
      checks++; if (bus.out_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid_%0d got=%b want=%b", n, bus.out_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        checks++; if (bus.out_data !== m_q[0]) begin errors++; $display("FAIL rnd_data_%0d got=%h want=%h", n, bus.out_data, m_q[0]); end
      end
      checks++; if (timer_irq !== m_irq) begin errors++; $display("FAIL rnd_irq_%0d got=%b want=%b", n, timer_irq, m_irq); end
      step();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ram();
    test_fifo_overflow();
    test_full_push_pop();
    test_timer_period();
    test_reset_mid();
    test_gpio_unmapped();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
